game_ctrl: RTL and testbench

- Per-frame game sequencer for the Space-Invaders-style display.
- Owns and updates every object coordinate the VGA renderer draws: alien group origin, alien alive mask, ship x, projectile x/y. Also owns the game-over flag.
- Runs on the pixel clock and updates state only on a one-cycle frame_tick, so renderer inputs stay stable during active video.
- Sits between the debounced button inputs and vga_top.

---
 rtl/game_pkg.sv | 42 ++++
 rtl/game_ctrl_alien_hit_detect.sv | 32 +++
 rtl/game_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared playfield geometry, state encoding and coordinate helpers for the
// game sequencer and the VGA renderer.
package game_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [10:0] wide_t;

  localparam coord_t LEFT_BOUND  = 10'd144;
  localparam coord_t RIGHT_BOUND = 10'd584;
  localparam coord_t TOP_BOUND   = 10'd134;
  localparam coord_t GRID        = 10'd40;
  localparam coord_t WIN_LINE    = 10'd444;
  localparam coord_t SHIP_W      = 10'd40;
  localparam coord_t PROJ_W      = 10'd14;

  localparam coord_t STEP_X      = 10'd40;
  localparam coord_t STEP_Y      = 10'd40;
  localparam coord_t SHIP_SPEED  = 10'd2;
  localparam coord_t PROJ_SPEED  = 10'd4;
  localparam int     MOVE_DIV    = 30;
  localparam logic [4:0] MOVE_LAST = 5'(MOVE_DIV - 1);

  localparam coord_t INACTIVE    = 10'h3FF;
  localparam coord_t SHIP_X0     = 10'd344;
  localparam coord_t SHIP_MAX    = RIGHT_BOUND - SHIP_W;
  localparam coord_t MARCH_MAX   = RIGHT_BOUND - 10'd200;
  localparam coord_t PROJ_XOFF   = 10'd13;
  localparam coord_t PROJ_Y0     = WIN_LINE - PROJ_W;
  localparam coord_t ROW2_SPAN   = 10'd120;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_OVER    = 2'd2
  } state_e;

  // Widening add so bound checks never wrap at 10 bits.
  function automatic wide_t wadd(input coord_t a, input coord_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/game_ctrl_alien_hit_detect.sv
// Projectile vs alien-cell overlap; returns the lowest-index live cell hit
// as a one-hot vector plus an any-hit flag.
module alien_hit_detect
  import game_pkg::*;
(
  input  logic [9:0] proj_x,
  input  logic [9:0] proj_y,
  input  logic [9:0] org_x,
  input  logic [9:0] org_y,
  input  logic [5:0] mask,
  output logic [5:0] hit_vec,
  output logic       hit
);

  logic [5:0] raw;

  for (genvar i = 0; i < 6; i++) begin : g_cell
    localparam logic [10:0] OFF_X = 11'(2 * GRID * (i % 3));
    localparam logic [10:0] OFF_Y = 11'(2 * GRID * (i / 3));
    logic [10:0] cx, cy;
    assign cx = {1'b0, org_x} + OFF_X;
    assign cy = {1'b0, org_y} + OFF_Y;
    // Strict inequalities so edge-touching squares do not count, as drawn.
    assign raw[i] = mask[i]
                    && ({1'b0, proj_x} < cx + {1'b0, GRID}) && (wadd(proj_x, PROJ_W) > cx)
                    && ({1'b0, proj_y} < cy + {1'b0, GRID}) && (wadd(proj_y, PROJ_W) > cy);
  end

  assign hit_vec = raw & (~raw + 6'd1);
  assign hit     = |raw;

endmodule

// File: rtl/game_ctrl.sv
// Per-frame game sequencer: ship, projectile, alien march and game-over,
// all updated together on frame_tick so renderer inputs stay stable.
module game_ctrl
  import game_pkg::*;
(
  input  logic       clk_25MHz,
  input  logic       d_reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic [9:0] aliens_x,
  output logic [9:0] aliens_y,
  output logic [5:0] index_aliens,
  output logic [9:0] ship_x,
  output logic [9:0] projectile_x,
  output logic [9:0] projectile_y,
  output logic       game_over,
  output logic       player_win
);

  state_e     state_q, state_d;
  logic [9:0] aliens_x_q, aliens_x_d, aliens_y_q, aliens_y_d;
  logic [9:0] ship_x_q, ship_x_d, proj_x_q, proj_x_d, proj_y_q, proj_y_d;
  logic [5:0] mask_q, mask_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       dir_left_q, dir_left_d, fire_prev_q, fire_prev_d;
  logic       fire_pend_q, fire_pend_d, game_over_q, game_over_d;
  logic       player_win_q, player_win_d;

  logic [9:0]  ship_nx, proj_x_mv, proj_y_mv, march_x, march_y;
  logic        march_left, cnt_wrap, hit;
  logic [5:0]  hit_vec, mask_nx;
  logic [10:0] bottom;

  always_comb begin
    ship_nx = ship_x_q;
    if (btn_left && !btn_right)
      ship_nx = ({1'b0, ship_x_q} < wadd(LEFT_BOUND, SHIP_SPEED)) ? LEFT_BOUND : ship_x_q - SHIP_SPEED;
    else if (btn_right && !btn_left)
      ship_nx = (wadd(ship_x_q, SHIP_SPEED) > {1'b0, SHIP_MAX}) ? SHIP_MAX : ship_x_q + SHIP_SPEED;

    proj_x_mv = proj_x_q;
    proj_y_mv = proj_y_q;
    if (proj_y_q != INACTIVE) begin
      if ({1'b0, proj_y_q} <= wadd(TOP_BOUND, PROJ_SPEED)) begin
        proj_x_mv = INACTIVE;
        proj_y_mv = INACTIVE;
      end else begin
        proj_y_mv = proj_y_q - PROJ_SPEED;
      end
    end else if (fire_pend_q) begin
      // Spawn from the ship position before this frame's move.
      proj_x_mv = ship_x_q + PROJ_XOFF;
      proj_y_mv = PROJ_Y0;
    end
  end

  alien_hit_detect u_hit (
    .proj_x  (proj_x_mv),
    .proj_y  (proj_y_mv),
    .org_x   (aliens_x_q),
    .org_y   (aliens_y_q),
    .mask    (mask_q),
    .hit_vec (hit_vec),
    .hit     (hit)
  );

  always_comb begin
    cnt_wrap   = (frame_cnt_q == MOVE_LAST);
    march_x    = aliens_x_q;
    march_y    = aliens_y_q;
    march_left = dir_left_q;
    if (cnt_wrap) begin
      if (!dir_left_q) begin
        if (wadd(aliens_x_q, STEP_X) > {1'b0, MARCH_MAX}) begin
          march_y    = aliens_y_q + STEP_Y;
          march_left = 1'b1;
        end else begin
          march_x = aliens_x_q + STEP_X;
        end
      end else begin
        if ({1'b0, aliens_x_q} < wadd(LEFT_BOUND, STEP_X)) begin
          march_y    = aliens_y_q + STEP_Y;
          march_left = 1'b0;
        end else begin
          march_x = aliens_x_q - STEP_X;
        end
      end
    end
    mask_nx = mask_q & ~hit_vec;
    bottom  = wadd(march_y, (|mask_nx[5:3]) ? ROW2_SPAN : GRID);
  end

  always_comb begin
    state_d      = state_q;
    aliens_x_d   = aliens_x_q;
    aliens_y_d   = aliens_y_q;
    mask_d       = mask_q;
    ship_x_d     = ship_x_q;
    proj_x_d     = proj_x_q;
    proj_y_d     = proj_y_q;
    frame_cnt_d  = frame_cnt_q;
    dir_left_d   = dir_left_q;
    game_over_d  = game_over_q;
    player_win_d = player_win_q;
    fire_prev_d  = btn_fire;
    fire_pend_d  = fire_pend_q | (btn_fire & ~fire_prev_q);
    if (frame_tick) begin
      fire_pend_d = 1'b0;
      unique case (state_q)
        ST_ATTRACT: if (fire_pend_q) state_d = ST_PLAY;
        ST_PLAY: begin
          ship_x_d    = ship_nx;
          proj_x_d    = hit ? INACTIVE : proj_x_mv;
          proj_y_d    = hit ? INACTIVE : proj_y_mv;
          mask_d      = mask_nx;
          frame_cnt_d = cnt_wrap ? 5'd0 : frame_cnt_q + 5'd1;
          aliens_x_d  = march_x;
          aliens_y_d  = march_y;
          dir_left_d  = march_left;
          if (mask_nx == 6'd0) begin
            state_d      = ST_OVER;
            game_over_d  = 1'b1;
            player_win_d = 1'b1;
          end else if (bottom >= {1'b0, WIN_LINE}) begin
            state_d      = ST_OVER;
            game_over_d  = 1'b1;
            player_win_d = 1'b0;
          end
        end
        ST_OVER: if (fire_pend_q) begin
          state_d      = ST_PLAY;
          aliens_x_d   = LEFT_BOUND;
          aliens_y_d   = TOP_BOUND;
          mask_d       = 6'b111111;
          ship_x_d     = SHIP_X0;
          proj_x_d     = INACTIVE;
          proj_y_d     = INACTIVE;
          frame_cnt_d  = 5'd0;
          dir_left_d   = 1'b0;
          game_over_d  = 1'b0;
          player_win_d = 1'b0;
        end
        default: state_d = ST_ATTRACT;
      endcase
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (d_reset) begin
      state_q      <= ST_ATTRACT;
      aliens_x_q   <= LEFT_BOUND;
      aliens_y_q   <= TOP_BOUND;
      mask_q       <= 6'b111111;
      ship_x_q     <= SHIP_X0;
      proj_x_q     <= INACTIVE;
      proj_y_q     <= INACTIVE;
      frame_cnt_q  <= 5'd0;
      dir_left_q   <= 1'b0;
      fire_prev_q  <= 1'b0;
      fire_pend_q  <= 1'b0;
      game_over_q  <= 1'b0;
      player_win_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      aliens_x_q   <= aliens_x_d;
      aliens_y_q   <= aliens_y_d;
      mask_q       <= mask_d;
      ship_x_q     <= ship_x_d;
      proj_x_q     <= proj_x_d;
      proj_y_q     <= proj_y_d;
      frame_cnt_q  <= frame_cnt_d;
      dir_left_q   <= dir_left_d;
      fire_prev_q  <= fire_prev_d;
      fire_pend_q  <= fire_pend_d;
      game_over_q  <= game_over_d;
      player_win_q <= player_win_d;
    end
  end

  assign aliens_x     = aliens_x_q;
  assign aliens_y     = aliens_y_q;
  assign index_aliens = mask_q;
  assign ship_x       = ship_x_q;
  assign projectile_x = proj_x_q;
  assign projectile_y = proj_y_q;
  assign game_over    = game_over_q;
  assign player_win   = player_win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: behavioural game model checked every cycle, directed
// phases for the landmark cases, an aiming bot for the win path, random play.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       d_reset = 1'b1, frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
  logic [9:0] aliens_x, aliens_y, ship_x, projectile_x, projectile_y;
  logic [5:0] index_aliens;
  logic       game_over, player_win;

  int n_tests = 0;
  int n_fail  = 0;

  game_ctrl dut (
    .clk_25MHz    (clk),
    .d_reset      (d_reset),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_fire     (btn_fire),
    .aliens_x     (aliens_x),
    .aliens_y     (aliens_y),
    .index_aliens (index_aliens),
    .ship_x       (ship_x),
    .projectile_x (projectile_x),
    .projectile_y (projectile_y),
    .game_over    (game_over),
    .player_win   (player_win)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game model: st 0=attract 1=play 2=over, dir 0=right 1=left.
  typedef struct {
    int st, ax, ay, mask, sx, px, py, dir, cnt, pend, prev, win;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.st = 0; r.ax = 144; r.ay = 134; r.mask = 63; r.sx = 344;
    r.px = 1023; r.py = 1023; r.dir = 0; r.cnt = 0; r.pend = 0; r.prev = 0; r.win = 0;
    return r;
  endfunction

  function automatic mdl_t play(mdl_t o, bit l, bit r);
    mdl_t n = o;
    int cx, cy, bottom;
    if (l && !r) n.sx = (o.sx - 2 < 144) ? 144 : o.sx - 2;
    if (r && !l) n.sx = (o.sx + 2 > 544) ? 544 : o.sx + 2;
    if (o.py != 1023) begin
      n.py = o.py - 4;
      if (n.py <= 134) begin n.px = 1023; n.py = 1023; end
    end else if (o.pend != 0) begin
      n.px = o.sx + 13; n.py = 430;
    end
    for (int i = 0; i < 6; i++) begin
      cx = o.ax + 80 * (i % 3);
      cy = o.ay + 80 * (i / 3);
      if (((o.mask >> i) & 1) == 1 && n.px < cx + 40 && n.px + 14 > cx
          && n.py < cy + 40 && n.py + 14 > cy) begin
        n.mask = o.mask & ~(1 << i);
        n.px = 1023; n.py = 1023;
        break;
      end
    end
    n.cnt = o.cnt + 1;
    if (n.cnt == 30) begin
      n.cnt = 0;
      if (o.dir == 0) begin
        if (o.ax + 40 > 384) begin n.ay = o.ay + 40; n.dir = 1; end
        else n.ax = o.ax + 40;
      end else begin
        if (o.ax - 40 < 144) begin n.ay = o.ay + 40; n.dir = 0; end
        else n.ax = o.ax - 40;
      end
    end
    if (n.mask == 0) begin
      n.st = 2; n.win = 1;
    end else begin
      bottom = n.ay + ((((n.mask >> 3) & 7) != 0) ? 120 : 40);
      if (bottom >= 444) begin n.st = 2; n.win = 0; end
    end
    return n;
  endfunction

  function automatic mdl_t mdl_next(mdl_t o, bit rst, bit tk, bit l, bit r, bit f);
    mdl_t n;
    if (rst) return mdl_rst();
    n = o;
    n.prev = int'(f);
    if (!tk) begin
      if (f && o.prev == 0) n.pend = 1;
      return n;
    end
    n.pend = 0;
    case (o.st)
      0: if (o.pend != 0) n.st = 1;
      1: begin n = play(o, l, r); n.prev = int'(f); n.pend = 0; end
      2: if (o.pend != 0) begin n = mdl_rst(); n.st = 1; n.prev = int'(f); end
      default: ;
    endcase
    return n;
  endfunction

  // Would a shot fired now from ship position x kill an alien?
  function automatic bit shot_hits(mdl_t o, int x);
    mdl_t s = o;
    s.sx = x; s.pend = 1; s.prev = 0;
    for (int k = 0; k < 120; k++) begin
      s = mdl_next(s, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (s.st != 1 || s.py == 1023) break;
    end
    return s.mask != o.mask;
  endfunction

  task automatic check_all();
    chk("aliens_x", aliens_x, m.ax);
    chk("aliens_y", aliens_y, m.ay);
    chk("index_aliens", index_aliens, m.mask);
    chk("ship_x", ship_x, m.sx);
    chk("projectile_x", projectile_x, m.px);
    chk("projectile_y", projectile_y, m.py);
    chk("game_over", game_over, (m.st == 2) ? 1 : 0);
    chk("player_win", player_win, m.win);
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit l, input bit r, input bit f);
    d_reset = rst; frame_tick = tk; btn_left = l; btn_right = r; btn_fire = f;
    @(posedge clk);
    m = mdl_next(m, rst, tk, l, r, f);
    @(negedge clk);
    check_all();
  endtask

  // One idle cycle (where a fire edge can register) followed by the tick.
  task automatic frame(input bit l, input bit r, input bit f);
    cyc(1'b0, 1'b0, l, r, f);
    cyc(1'b0, 1'b1, l, r, f);
  endtask

  initial begin
    bit l, r, f;
    int best, d_best, d_x;
    m = mdl_rst();

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_aliens_x", aliens_x, 144);
    chk("rst_aliens_y", aliens_y, 134);
    chk("rst_mask", index_aliens, 6'b111111);
    chk("rst_ship", ship_x, 344);
    chk("rst_proj_x", projectile_x, 10'h3FF);
    chk("rst_game_over", game_over, 0);

    repeat (3) frame(1'b0, 1'b0, 1'b0);
    chk("attract_aliens_x", aliens_x, 144);
    chk("attract_proj_y", projectile_y, 10'h3FF);
    chk("attract_mask", index_aliens, 6'b111111);

    frame(1'b0, 1'b0, 1'b1);
    chk("start_no_proj", projectile_y, 10'h3FF);
    repeat (150) frame(1'b1, 1'b0, 1'b0);
    chk("ship_clamp_left", ship_x, 144);
    repeat (10) frame(1'b1, 1'b1, 1'b0);
    chk("ship_both_hold", ship_x, 144);
    repeat (100) frame(1'b0, 1'b1, 1'b0);
    chk("ship_back_344", ship_x, 344);

    frame(1'b0, 1'b0, 1'b1);
    chk("spawn_x", projectile_x, 357);
    chk("spawn_y", projectile_y, 430);
    frame(1'b0, 1'b0, 1'b0);
    chk("proj_move_y", projectile_y, 426);
    frame(1'b0, 1'b0, 1'b1);
    chk("refire_y", projectile_y, 422);
    chk("refire_x", projectile_x, 357);

    for (int k = 0; k < 3000 && !game_over; k++) frame(1'b0, 1'b0, 1'b0);
    chk("loss_over", game_over, 1);
    chk("loss_win", player_win, 0);
    chk("loss_aliens_y", aliens_y, 334);

    repeat (3) frame(1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    chk("restart_aliens_x", aliens_x, 144);
    chk("restart_aliens_y", aliens_y, 134);
    chk("restart_mask", index_aliens, 6'b111111);
    chk("restart_ship", ship_x, 344);
    chk("restart_over", game_over, 0);
    frame(1'b0, 1'b0, 1'b0);

    // Aiming bot: fire when the model says the shot connects, else steer.
    for (int k = 0; k < 4000 && !game_over; k++) begin
      l = 1'b0; r = 1'b0; f = 1'b0;
      if (m.st == 1 && m.py == 1023) begin
        if (shot_hits(m, m.sx)) f = 1'b1;
        else begin
          best = -1; d_best = 1000;
          for (int x = 144; x <= 544; x += 4) begin
            d_x = (x > m.sx) ? x - m.sx : m.sx - x;
            if (d_x < d_best && shot_hits(m, x)) begin best = x; d_best = d_x; end
          end
          if (best > m.sx) r = 1'b1;
          else if (best >= 0 && best < m.sx) l = 1'b1;
        end
      end
      frame(l, r, f);
    end
    chk("win_over", game_over, 1);
    chk("win_flag", player_win, 1);
    chk("win_mask", index_aliens, 0);

    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 4) == 0);
      frame(l, r, f);
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, l, r, f);
      if (k == 250) begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_ship", ship_x, 344);
        chk("midrst_proj", projectile_y, 10'h3FF);
        chk("midrst_over", game_over, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
